// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO family; the dual-clock variant is expected to reuse these defaults.
package fifo_pkg;

    localparam int unsigned FIFO_DEF_SIZE  = 8;
    localparam int unsigned FIFO_DEF_WIDTH = 8;

endpackage

// File: rtl/fifo_flags.sv
// Pointer comparator: derives full, empty and occupancy from the wrap-bit-extended pointers.
module fifo_flags #(
    parameter int PTR_LEN = 3
) (
    input  logic [PTR_LEN:0] i_wr_ptr,
    input  logic [PTR_LEN:0] i_rd_ptr,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_LEN:0] o_level
);

    logic w_wrap_differs;
    logic w_addr_equal;

    assign w_wrap_differs = (i_wr_ptr[PTR_LEN] != i_rd_ptr[PTR_LEN]);
    assign w_addr_equal   = (i_wr_ptr[PTR_LEN-1:0] == i_rd_ptr[PTR_LEN-1:0]);

    assign o_empty = (i_wr_ptr == i_rd_ptr);
    assign o_full  = w_wrap_differs && w_addr_equal;
    // Modular subtraction is exact because the extra wrap bit covers the range 0..SIZE.
    assign o_level = i_wr_ptr - i_rd_ptr;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: register array, wrap-bit pointers and a registered read port.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int SIZE    = FIFO_DEF_SIZE,
    parameter int WIDTH   = FIFO_DEF_WIDTH,
    parameter int PTR_LEN = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [PTR_LEN:0] level
);

    localparam logic [PTR_LEN:0] PTR_ONE = (PTR_LEN+1)'(1);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [PTR_LEN:0] r_wr_ptr;
    logic [PTR_LEN:0] r_rd_ptr;
    logic [WIDTH-1:0] r_data_out;

    logic             w_full;
    logic             w_empty;
    logic [PTR_LEN:0] w_level;
    logic             w_wr_acc;
    logic             w_rd_acc;

    fifo_flags #(
        .PTR_LEN (PTR_LEN)
    ) u_flags (
        .i_wr_ptr (r_wr_ptr),
        .i_rd_ptr (r_rd_ptr),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (w_level)
    );

    // Acceptance uses pre-edge flags, so a full FIFO still reads and an empty one still writes.
    assign w_wr_acc = w_en && !w_full;
    assign w_rd_acc = r_en && !w_empty;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr[PTR_LEN-1:0]];
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[PTR_LEN-1:0]] <= data_in;
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed bench for sync_fifo_core with SIZE=8, WIDTH=8 and hand-computed expectations.
module tb_sync_fifo_core;

    logic       clk;
    logic       arst_n;
    logic       w_en;
    logic [7:0] data_in;
    logic       r_en;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [3:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo_core #(
        .SIZE  (8),
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .w_en     (w_en),
        .data_in  (data_in),
        .r_en     (r_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] e_dout, input logic [3:0] e_lvl,
                             input logic e_full, input logic e_empty);
        chk({tag, ".data_out"}, 32'(data_out), 32'(e_dout));
        chk({tag, ".level"},    32'(level),    32'(e_lvl));
        chk({tag, ".full"},     32'(full),     32'(e_full));
        chk({tag, ".empty"},    32'(empty),    32'(e_empty));
    endtask

    // Apply one cycle of inputs and sample 1 time unit after the rising edge.
    task automatic cycle(input logic we, input logic [7:0] din, input logic re);
        w_en    = we;
        data_in = din;
        r_en    = re;
        @(posedge clk);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = 8'h00;
    endtask

    initial begin
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = 8'h00;
        arst_n  = 1'b0;

        #12;
        chk_state("reset", 8'h00, 4'd0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_state("idle", 8'h00, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk_state("underflow", 8'h00, 4'd0, 1'b0, 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h11 + i), 1'b0);
            chk("fill.level", 32'(level), 32'(i + 1));
        end
        chk_state("filled", 8'h00, 4'd8, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        chk_state("overflow", 8'h00, 4'd8, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("drain.data", 32'(data_out), 32'(8'h11 + i));
            chk("drain.level", 32'(level), 32'(7 - i));
        end
        chk_state("drained", 8'h18, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("hold_empty", 32'(data_out), 32'h18);

        // Write+read starting from empty: the first read is ignored, the rest trail by one word.
        cycle(1'b1, 8'hC1, 1'b1);
        chk_state("wr_rd_empty", 8'h18, 4'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b1);
        chk_state("wr_rd2", 8'hC1, 4'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b1);
        chk_state("wr_rd3", 8'hC2, 4'd1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk_state("wr_rd_tail", 8'hC3, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'hA0 + i), 1'b0);
        end
        chk_state("wrap_full", 8'hC3, 4'd8, 1'b1, 1'b0);

        cycle(1'b1, 8'hEE, 1'b1);
        chk_state("wr_rd_full", 8'hA0, 4'd7, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("wrap_drain.data", 32'(data_out), 32'(8'hA0 + i));
        end
        chk_state("wrap_empty", 8'hA7, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("no_ee_stored", 32'(data_out), 32'hA7);

        cycle(1'b1, 8'h5A, 1'b1);
        chk_state("prime_5a", 8'hA7, 4'd1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b1);
            chk("stream.data", 32'(data_out), (i == 0) ? 32'h5A : 32'(8'h60 + i - 1));
            chk("stream.level", 32'(level), 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk_state("stream_end", 8'h73, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h31 + i), 1'b0);
        end
        chk_state("pre_reset", 8'h73, 4'd5, 1'b0, 1'b0);
        #1;
        arst_n = 1'b0;
        #1;
        chk_state("mid_reset", 8'h00, 4'd0, 1'b0, 1'b1);
        #2;
        arst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        chk_state("post_reset_rd", 8'h00, 4'd0, 1'b0, 1'b1);
        cycle(1'b1, 8'h42, 1'b0);
        chk_state("post_reset_wr", 8'h00, 4'd1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk_state("post_reset_rd2", 8'h42, 4'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
